// File: rtl/vshader_pkg.sv
// rtl/vshader_pkg.sv - shared opcodes, default geometry and lane helper for the vertex shader ALU
package vshader_pkg;

  localparam int VS_LANES   = 4;
  localparam int VS_W       = 32;
  localparam int VS_MAX_VEC = 512;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_MUL = 6'd3;
  localparam logic [5:0] OP_DP  = 6'd4;
  localparam logic [5:0] OP_MIN = 6'd5;
  localparam logic [5:0] OP_MAX = 6'd6;

  // Lane 0 sits in the MSBs; the caller truncates the result to its element width.
  function automatic logic [63:0] lane_get(input logic [VS_MAX_VEC-1:0] vec, input int lanes,
                                           input int w, input int i);
    return 64'(vec >> (w * (lanes - 1 - i)));
  endfunction

endpackage

// File: rtl/vshader_lane.sv
// rtl/vshader_lane.sv - per-lane arithmetic for the vector ALU second stage
module vshader_lane
  import vshader_pkg::*;
#(
  parameter int W = VS_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff,
  output logic [W-1:0] prod,
  output logic [W-1:0] min_v,
  output logic [W-1:0] max_v
);

  logic lt;

  assign lt    = $signed(a) < $signed(b);
  assign sum   = a + b;
  assign diff  = a - b;
  assign prod  = a * b;
  assign min_v = lt ? a : b;
  assign max_v = lt ? b : a;

endmodule

// File: rtl/vshader_alu.sv
// rtl/vshader_alu.sv - three-stage pipelined vector integer ALU with valid/ready flow control
module vshader_alu
  import vshader_pkg::*;
#(
  parameter int LANES = VS_LANES,
  parameter int W     = VS_W,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               iValid,
  output logic               oAccept,
  input  logic [LANES*W-1:0] iA,
  input  logic [LANES*W-1:0] iB,
  input  logic [5:0]         iALU_Op,
  input  logic [TAG_W-1:0]   iTag,
  output logic               oValid,
  input  logic               iReady,
  output logic [LANES*W-1:0] oResult,
  output logic [TAG_W-1:0]   oTag,
  output logic               oErr
);

  localparam int VW = LANES * W;

  logic             s1_valid, s2_valid, s3_valid;
  logic             s2_ready, s3_ready;
  logic [VW-1:0]    s1_a, s1_b;
  logic [5:0]       s1_op, s2_op;
  logic [TAG_W-1:0] s1_tag, s2_tag;

  logic [W-1:0] l_sum[LANES], l_diff[LANES], l_prod[LANES], l_min[LANES], l_max[LANES];
  logic [W-1:0] s2_sum[LANES], s2_diff[LANES], s2_prod[LANES], s2_min[LANES], s2_max[LANES];

  logic [W-1:0]  dp;
  logic [VW-1:0] res_d;
  logic          err_d;

  // A stage may load when it is empty or its contents leave this cycle.
  assign s3_ready = !s3_valid || iReady;
  assign s2_ready = !s2_valid || s3_ready;
  assign oAccept  = !s1_valid || s2_ready;
  assign oValid   = s3_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (oAccept)  s1_valid <= iValid;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (iValid && oAccept) begin
      s1_a   <= iA;
      s1_b   <= iB;
      s1_op  <= iALU_Op;
      s1_tag <= iTag;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vshader_lane #(.W(W)) u_lane (
      .a    (W'(lane_get(VS_MAX_VEC'(s1_a), LANES, W, i))),
      .b    (W'(lane_get(VS_MAX_VEC'(s1_b), LANES, W, i))),
      .sum  (l_sum[i]),
      .diff (l_diff[i]),
      .prod (l_prod[i]),
      .min_v(l_min[i]),
      .max_v(l_max[i])
    );
  end

  always_ff @(posedge clk) begin
    if (s1_valid && s2_ready) begin
      s2_op  <= s1_op;
      s2_tag <= s1_tag;
      for (int i = 0; i < LANES; i++) begin
        s2_sum[i]  <= l_sum[i];
        s2_diff[i] <= l_diff[i];
        s2_prod[i] <= l_prod[i];
        s2_min[i]  <= l_min[i];
        s2_max[i]  <= l_max[i];
      end
    end
  end

  always_comb begin
    dp    = '0;
    res_d = '0;
    err_d = 1'b0;
    for (int i = 0; i < LANES; i++) dp = dp + s2_prod[i];
    for (int i = 0; i < LANES; i++) begin
      case (s2_op)
        OP_ADD:  res_d[W*(LANES-1-i) +: W] = s2_sum[i];
        OP_SUB:  res_d[W*(LANES-1-i) +: W] = s2_diff[i];
        OP_MUL:  res_d[W*(LANES-1-i) +: W] = s2_prod[i];
        OP_DP:   res_d[W*(LANES-1-i) +: W] = dp;
        OP_MIN:  res_d[W*(LANES-1-i) +: W] = s2_min[i];
        OP_MAX:  res_d[W*(LANES-1-i) +: W] = s2_max[i];
        default: err_d = 1'b1;
      endcase
    end
  end

  // Output registers load only on a real advance, so they hold steady under stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oResult <= '0;
      oTag    <= '0;
      oErr    <= 1'b0;
    end else if (s2_valid && s3_ready) begin
      oResult <= res_d;
      oTag    <= s2_tag;
      oErr    <= err_d;
    end
  end

endmodule

// File: tb/tb_vshader_alu.sv
// tb/tb_vshader_alu.sv - scoreboard bench for vshader_alu
module tb_vshader_alu;
  import vshader_pkg::*;

  localparam int L  = VS_LANES;
  localparam int W  = VS_W;
  localparam int TW = 4;
  localparam int VW = L * W;

  logic          clk, resetn, iValid, oAccept, oValid, iReady, oErr;
  logic [VW-1:0] iA, iB, oResult;
  logic [5:0]    iALU_Op;
  logic [TW-1:0] iTag, oTag;

  typedef struct {
    logic [VW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  vshader_alu #(.LANES(L), .W(W), .TAG_W(TW)) dut (
    .clk(clk), .resetn(resetn), .iValid(iValid), .oAccept(oAccept),
    .iA(iA), .iB(iB), .iALU_Op(iALU_Op), .iTag(iTag),
    .oValid(oValid), .iReady(iReady), .oResult(oResult), .oTag(oTag), .oErr(oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic exp_t mk(input logic [VW-1:0] res, input logic [TW-1:0] tag, input logic err);
    exp_t e;
    e.res = res;
    e.tag = tag;
    e.err = err;
    return e;
  endfunction

  function automatic exp_t model(input logic [5:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [TW-1:0] tag);
    exp_t e;
    logic [W-1:0] x, y, r, acc;
    e.res = '0;
    e.tag = tag;
    e.err = !(op inside {OP_ADD, OP_SUB, OP_MUL, OP_DP, OP_MIN, OP_MAX});
    acc = '0;
    for (int i = 0; i < L; i++) acc += a[W*(L-1-i) +: W] * b[W*(L-1-i) +: W];
    for (int i = 0; i < L; i++) begin
      x = a[W*(L-1-i) +: W];
      y = b[W*(L-1-i) +: W];
      case (op)
        OP_ADD:  r = x + y;
        OP_SUB:  r = x - y;
        OP_MUL:  r = x * y;
        OP_DP:   r = acc;
        OP_MIN:  r = ($signed(x) < $signed(y)) ? x : y;
        OP_MAX:  r = ($signed(x) < $signed(y)) ? y : x;
        default: r = '0;
      endcase
      e.res[W*(L-1-i) +: W] = r;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [5:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [TW-1:0] tag, input exp_t e, input bit rnd);
    int waited = 0;
    iValid = 1'b1; iALU_Op = op; iA = a; iB = b; iTag = tag;
    forever begin
      @(negedge clk);
      if (oAccept) break;
      waited++;
      if (waited > 200) begin
        check("accept_wait", VW'(oAccept), VW'(1));
        iValid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd) iReady = 1'($urandom_range(0, 1));
    end
    sb.push_back(e);
    @(posedge clk); #1;
    iValid = 1'b0;
    if (rnd) iReady = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    iReady = 1'b1;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("drain_empty", VW'(sb.size()), VW'(0));
  endtask

  // Output monitor: scoreboard pop on each transfer, hold check across stalled cycles.
  initial begin
    exp_t          e;
    logic          prev_stall;
    logic [VW-1:0] hold_res;
    logic [TW-1:0] hold_tag;
    logic          hold_err;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (prev_stall && oValid) begin
          check("hold_res", oResult, hold_res);
          check("hold_tag", VW'(oTag), VW'(hold_tag));
          check("hold_err", VW'(oErr), VW'(hold_err));
        end
        if (oValid && iReady) begin
          check("sb_nonempty", VW'(sb.size() != 0), VW'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result", oResult, e.res);
            check("tag", VW'(oTag), VW'(e.tag));
            check("err", VW'(oErr), VW'(e.err));
          end
        end
        prev_stall = oValid && !iReady;
        hold_res = oResult; hold_tag = oTag; hold_err = oErr;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]    ops[10];
    logic [VW-1:0] va[10], vb[10];
    logic [VW-1:0] ma, mb;
    int            acc, k, stale;

    resetn = 1'b1; iValid = 1'b0; iReady = 1'b1;
    iA = '0; iB = '0; iALU_Op = '0; iTag = '0;
    #3 resetn = 1'b0;
    #1;
    check("rst_ovalid", VW'(oValid), VW'(0));
    check("rst_oresult", oResult, '0);
    check("rst_otag", VW'(oTag), VW'(0));
    check("rst_oerr", VW'(oErr), VW'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_oaccept", VW'(oAccept), VW'(1));
    @(posedge clk); #1;

    // ADD wrap and latency
    iValid = 1'b1; iALU_Op = OP_ADD; iTag = 4'd1;
    iA = {32'hFFFFFFFF, 32'd1, 32'd2, 32'd3};
    iB = {32'd1, 32'd1, 32'd1, 32'd1};
    sb.push_back(mk({32'd0, 32'd2, 32'd3, 32'd4}, 4'd1, 1'b0));
    @(posedge clk); #1;
    iValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lat_early", VW'(oValid), VW'(0));
    @(negedge clk);
    check("lat_ready", VW'(oValid), VW'(1));
    drain();

    send(OP_DP, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 4'd2,
         mk({4{32'h46}}, 4'd2, 1'b0), 1'b0);
    ma = {32'hABCD, 32'h1234, 32'h2345, 32'h3456};
    mb = {32'hBCDA, 32'h2341, 32'h3452, 32'h4563};
    send(OP_DP, ma, mb, 4'd3, model(OP_DP, ma, mb, 4'd3), 1'b0);
    ma = {32'hFFFFFFFF, 32'd5, 32'd0, 32'h80000000};
    mb = {32'd1, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF};
    send(OP_MIN, ma, mb, 4'd4, mk({32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000}, 4'd4, 1'b0), 1'b0);
    send(OP_MAX, ma, mb, 4'd5, mk({32'd1, 32'd5, 32'd0, 32'h7FFFFFFF}, 4'd5, 1'b0), 1'b0);
    ma = {$urandom, $urandom, $urandom, $urandom};
    mb = {$urandom, $urandom, $urandom, $urandom};
    send(OP_SUB, ma, mb, 4'd6, model(OP_SUB, ma, mb, 4'd6), 1'b0);
    send(OP_MUL, ma, mb, 4'd7, model(OP_MUL, ma, mb, 4'd7), 1'b0);
    drain();

    // Backpressure: sustained stall first, then random ready
    for (int i = 0; i < 10; i++) begin
      ops[i] = 6'(i % 6 + 1);
      va[i] = {$urandom, $urandom, $urandom, $urandom};
      vb[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    iReady = 1'b0;
    acc = 0;
    iValid = 1'b1; iALU_Op = ops[0]; iA = va[0]; iB = vb[0]; iTag = 4'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (oAccept) begin
        sb.push_back(model(ops[acc], va[acc], vb[acc], TW'(acc)));
        acc++;
      end
      @(posedge clk); #1;
      iALU_Op = ops[acc]; iA = va[acc]; iB = vb[acc]; iTag = TW'(acc);
    end
    check("stall_accepts", VW'(acc), VW'(3));
    check("stall_oaccept", VW'(oAccept), VW'(0));
    for (k = acc; k < 10; k++) send(ops[k], va[k], vb[k], TW'(k), model(ops[k], va[k], vb[k], TW'(k)), 1'b1);
    drain();

    // Illegal op between legal ones
    ma = {32'd10, 32'd20, 32'd30, 32'd40};
    mb = {32'd1, 32'd2, 32'd3, 32'd4};
    send(OP_ADD, ma, mb, 4'd1, mk({32'd11, 32'd22, 32'd33, 32'd44}, 4'd1, 1'b0), 1'b0);
    send(6'h3F, ma, mb, 4'd2, mk('0, 4'd2, 1'b1), 1'b0);
    send(OP_SUB, ma, mb, 4'd3, mk({32'd9, 32'd18, 32'd27, 32'd36}, 4'd3, 1'b0), 1'b0);
    drain();

    // Reset with three ops in flight
    iReady = 1'b0;
    send(OP_ADD, ma, mb, 4'd9, model(OP_ADD, ma, mb, 4'd9), 1'b0);
    send(OP_MAX, ma, mb, 4'd10, model(OP_MAX, ma, mb, 4'd10), 1'b0);
    send(OP_MUL, ma, mb, 4'd11, model(OP_MUL, ma, mb, 4'd11), 1'b0);
    @(negedge clk);
    check("pre_rst_ovalid", VW'(oValid), VW'(1));
    @(posedge clk);
    #3 resetn = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_ovalid", VW'(oValid), VW'(0));
    check("mid_rst_oresult", oResult, '0);
    check("mid_rst_otag", VW'(oTag), VW'(0));
    check("mid_rst_oerr", VW'(oErr), VW'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    iReady = 1'b1;
    @(negedge clk);
    check("post_rst_oaccept", VW'(oAccept), VW'(1));
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (oValid) stale++;
    end
    check("post_rst_stale", VW'(stale), VW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
